alarm_timer: RTL and testbench

ALARM_TIMER -- requirements
Module: alarm_timer

---
 rtl/alarm_timer.sv | 120 ++++++++++++
 tb/tb_alarm_timer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_timer.sv
// Alarm interval timer: free-running 1 Hz prescaler, seconds down-counter and expiry pulse.
// Define ALARM_TIMER_HALF_HZ_EN to build the half-rate siren strobe (half_hz_enable).
module alarm_timer #(
    parameter int CLK_FREQ = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_timer,
    input  logic       stop_timer,
    input  logic [3:0] value,
    output logic       expired,
    output logic       busy,
    output logic [3:0] count,
    output logic       one_hz_enable,
    output logic       half_hz_enable
);

    localparam int PW = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLK_FREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNTING,
        EXPIRED
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] prescaler;
    logic          start_load;
    logic          last_second;

    // A stop request always wins, so a start only takes effect when stop is low.
    assign start_load  = start_timer && !stop_timer;
    assign last_second = (count == 4'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (start_load || (prescaler == PRESCALE_LAST)) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign one_hz_enable = (prescaler == PRESCALE_LAST);

`ifdef ALARM_TIMER_HALF_HZ_EN
    logic phase;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase <= 1'b0;
        end else if (start_load) begin
            phase <= 1'b0;
        end else if (one_hz_enable) begin
            phase <= ~phase;
        end
    end

    assign half_hz_enable = one_hz_enable && phase;
`else
    assign half_hz_enable = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_timer) begin
            state_d = IDLE;
        end else if (start_timer) begin
            state_d = (value != 4'd0) ? COUNTING : EXPIRED;
        end else begin
            case (state_q)
                COUNTING: begin
                    if (one_hz_enable && last_second) begin
                        state_d = EXPIRED;
                    end
                end
                EXPIRED:  state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = 1'b0;
        expired = 1'b0;
        case (state_q)
            COUNTING: busy    = 1'b1;
            EXPIRED:  expired = 1'b1;
            default: begin
                busy    = 1'b0;
                expired = 1'b0;
            end
        endcase
    end

    // Count is only ever nonzero while COUNTING, so the tick that leaves 1 lands on 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else if (stop_timer) begin
            count <= 4'd0;
        end else if (start_timer) begin
            count <= value;
        end else if ((state_q == COUNTING) && one_hz_enable) begin
            count <= count - 4'd1;
        end
    end

endmodule

// File: tb/tb_alarm_timer.sv
// Self-checking bench for alarm_timer: directed vector table, corner sequences and
// randomized traffic against a time-arithmetic reference model.
module tb_alarm_timer;

    localparam int CF = 4;
`ifdef ALARM_TIMER_HALF_HZ_EN
    localparam bit HALF_EN = 1'b1;
`else
    localparam bit HALF_EN = 1'b0;
`endif

    typedef struct packed {
        logic       expired;
        logic       busy;
        logic [3:0] count;
        logic       one_hz;
        logic       half;
    } expect_t;

    typedef struct {
        bit         start;
        bit         stop;
        logic [3:0] value;
        expect_t    exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start_timer = 1'b0;
    logic       stop_timer = 1'b0;
    logic [3:0] value = 4'd0;
    logic       expired;
    logic       busy;
    logic [3:0] count;
    logic       one_hz_enable;
    logic       half_hz_enable;

    int total = 0;
    int bad = 0;

    // Reference model: edges since reset, plus the edge/value of the latest start.
    int n = 0;
    int origin = 0;
    int run_k = 0;
    int run_val = 0;
    bit has_run = 1'b0;

    alarm_timer #(.CLK_FREQ(CF)) dut (
        .clock(clock),
        .reset(reset),
        .start_timer(start_timer),
        .stop_timer(stop_timer),
        .value(value),
        .expired(expired),
        .busy(busy),
        .count(count),
        .one_hz_enable(one_hz_enable),
        .half_hz_enable(half_hz_enable)
    );

    always #5 clock = ~clock;

    task automatic modelEdge(input bit st, input bit sp, input logic [3:0] v);
        n++;
        if (sp) begin
            has_run = 1'b0;
        end else if (st) begin
            has_run = 1'b1;
            run_k   = n;
            run_val = int'(v);
            origin  = n;
        end
    endtask

    function automatic expect_t modelExpect();
        expect_t e;
        int since;
        int end_edge;
        e = '0;
        since = n - origin;
        e.one_hz = ((since % CF) == CF - 1);
        e.half = HALF_EN && e.one_hz && (((since / CF) % 2) == 1);
        if (has_run) begin
            end_edge = run_k + run_val * CF;
            if (n < end_edge) begin
                e.busy  = 1'b1;
                e.count = 4'(run_val - (n - run_k) / CF);
            end else if (n == end_edge) begin
                e.expired = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic vec_t mkVec(input bit st, input bit sp, input logic [3:0] v,
                                   input bit ex, input bit bz, input logic [3:0] c,
                                   input bit oh, input bit hf);
        vec_t r;
        r.start = st;
        r.stop = sp;
        r.value = v;
        r.exp.expired = ex;
        r.exp.busy = bz;
        r.exp.count = c;
        r.exp.one_hz = oh;
        r.exp.half = hf && HALF_EN;
        return r;
    endfunction

    task automatic compareInt(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic checkOutput(input string name, input expect_t e);
        compareInt({name, ".expired"}, int'(expired), int'(e.expired));
        compareInt({name, ".busy"}, int'(busy), int'(e.busy));
        compareInt({name, ".count"}, int'(count), int'(e.count));
        compareInt({name, ".one_hz"}, int'(one_hz_enable), int'(e.one_hz));
        compareInt({name, ".half_hz"}, int'(half_hz_enable), int'(e.half));
    endtask

    // Inputs are held across one rising edge, then scrambled so value is never trusted later.
    task automatic applyStimulus(input bit st, input bit sp, input logic [3:0] v);
        start_timer = st;
        stop_timer  = sp;
        value       = v;
        @(posedge clock);
        modelEdge(st, sp, v);
        #1;
        start_timer = 1'b0;
        stop_timer  = 1'b0;
        value       = 4'($urandom_range(15));
    endtask

    task automatic idleSteps(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b0, 1'b0, 4'($urandom_range(15)));
            checkOutput(name, modelExpect());
        end
    endtask

    task automatic pulseReset(input string name);
        #2;
        reset = 1'b0;
        #1;
        checkOutput({name, ".async"}, '0);
        @(posedge clock);
        #1;
        checkOutput({name, ".held"}, '0);
        #2;
        reset   = 1'b1;
        n       = 0;
        origin  = 0;
        has_run = 1'b0;
    endtask

    vec_t vecs[16];

    initial begin
        int ones;
        int halves;
        int waited;
        bit seen;

        vecs[0]  = mkVec(1, 0, 4'd3, 0, 1, 4'd3, 0, 0);
        vecs[1]  = mkVec(0, 0, 4'd9, 0, 1, 4'd3, 0, 0);
        vecs[2]  = mkVec(0, 0, 4'd1, 0, 1, 4'd3, 0, 0);
        vecs[3]  = mkVec(0, 0, 4'd0, 0, 1, 4'd3, 1, 0);
        vecs[4]  = mkVec(0, 0, 4'd7, 0, 1, 4'd2, 0, 0);
        vecs[5]  = mkVec(0, 0, 4'd7, 0, 1, 4'd2, 0, 0);
        vecs[6]  = mkVec(0, 0, 4'd7, 0, 1, 4'd2, 0, 0);
        vecs[7]  = mkVec(0, 0, 4'd7, 0, 1, 4'd2, 1, 1);
        vecs[8]  = mkVec(0, 0, 4'd2, 0, 1, 4'd1, 0, 0);
        vecs[9]  = mkVec(0, 0, 4'd2, 0, 1, 4'd1, 0, 0);
        vecs[10] = mkVec(0, 0, 4'd2, 0, 1, 4'd1, 0, 0);
        vecs[11] = mkVec(0, 0, 4'd2, 0, 1, 4'd1, 1, 0);
        vecs[12] = mkVec(0, 0, 4'd5, 1, 0, 4'd0, 0, 0);
        vecs[13] = mkVec(0, 0, 4'd5, 0, 0, 4'd0, 0, 0);
        vecs[14] = mkVec(1, 0, 4'd0, 1, 0, 4'd0, 0, 0);
        vecs[15] = mkVec(0, 0, 4'd6, 0, 0, 4'd0, 0, 0);

        #1;
        checkOutput("reset", '0);
        @(posedge clock);
        #3;
        reset = 1'b1;

        ones = 0;
        halves = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0);
            checkOutput("cadence", modelExpect());
            ones += int'(one_hz_enable);
            halves += int'(half_hz_enable);
        end
        compareInt("cadence.one_hz_pulses", ones, 4);
        compareInt("cadence.half_hz_pulses", halves, HALF_EN ? 2 : 0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].value);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        applyStimulus(1'b1, 1'b0, 4'd5);
        checkOutput("restart.first", modelExpect());
        idleSteps("restart.run", 5);
        applyStimulus(1'b1, 1'b0, 4'd2);
        checkOutput("restart.again", modelExpect());
        waited = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus(1'b0, 1'b0, 4'($urandom_range(15)));
            checkOutput("restart.wait", modelExpect());
            waited++;
            seen = expired;
        end
        compareInt("restart.expiry_delay", seen ? waited : -1, 2 * CF);
        idleSteps("restart.after", 3);

        applyStimulus(1'b1, 1'b0, 4'd4);
        idleSteps("stop.run", 5);
        applyStimulus(1'b0, 1'b1, 4'd9);
        compareInt("stop.busy", int'(busy), 0);
        checkOutput("stop.now", modelExpect());
        idleSteps("stop.after", 20);

        applyStimulus(1'b1, 1'b0, 4'd3);
        idleSteps("both.run", 2);
        applyStimulus(1'b1, 1'b1, 4'd7);
        checkOutput("both.now", mkVec(0, 0, 4'd0, 0, 0, 4'd0, one_hz_enable, 0).exp);
        checkOutput("both.model", modelExpect());
        idleSteps("both.after", 16);

        applyStimulus(1'b1, 1'b0, 4'd6);
        idleSteps("rstmid.run", 5);
        pulseReset("rstmid");
        waited = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0);
            checkOutput("rstmid.wait", modelExpect());
            waited++;
            seen = one_hz_enable;
        end
        compareInt("rstmid.first_one_hz_edge", seen ? waited : -1, CF - 1);
        idleSteps("rstmid.after", 30);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(11) == 0, $urandom_range(29) == 0,
                          4'($urandom_range(15)));
            checkOutput("random", modelExpect());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
